// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Request-to-send, 10-bit LSB-first shift with odd parity, device ack check.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int SETUP_CYCLES   = 250,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  input  logic       SCLK_IN,
  input  logic       SDATA_IN,
  output logic       SCLK_OE,
  output logic       SDATA_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int DLY_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int DW = $clog2(DLY_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] INH_LAST = DW'(INHIBIT_CYCLES - 1);
  localparam logic [DW-1:0] SET_LAST = DW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_SETUP, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] dly, dly_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [9:0]    shift, shift_n;
  logic          data_oe, data_oe_n;
  logic          done_r, done_n;
  logic          err_r, err_n;
  logic          timed;

  logic sclk_s1, sclk_s2, sclk_prev, sdata_s1, sdata_s2, fall;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_s1   <= 1'b1;
      sclk_s2   <= 1'b1;
      sclk_prev <= 1'b1;
      sdata_s1  <= 1'b1;
      sdata_s2  <= 1'b1;
      fall      <= 1'b0;
    end else begin
      sclk_s1   <= SCLK_IN;
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      sdata_s1  <= SDATA_IN;
      sdata_s2  <= sdata_s1;
      fall      <= sclk_prev & ~sclk_s2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      dly     <= '0;
      tcnt    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      data_oe <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state   <= state_n;
      dly     <= dly_n;
      tcnt    <= tcnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      data_oe <= data_oe_n;
      done_r  <= done_n;
      err_r   <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    dly_n     = dly;
    tcnt_n    = tcnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    data_oe_n = data_oe;
    done_n    = 1'b0;
    err_n     = 1'b0;
    timed     = 1'b0;

    if (state == S_SEND || state == S_ACK || state == S_WAIT_IDLE) begin
      tcnt_n = tcnt + 1'b1;
      timed  = (tcnt == TO_LAST);
    end

    case (state)
      S_IDLE: begin
        data_oe_n = 1'b0;
        if (TX_START) begin
          shift_n = {1'b1, ~^TX_DATA, TX_DATA};
          dly_n   = '0;
          state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (dly == INH_LAST) begin
          dly_n     = '0;
          data_oe_n = 1'b1;
          state_n   = S_SETUP;
        end else begin
          dly_n = dly + 1'b1;
        end
      end
      S_SETUP: begin
        if (dly == SET_LAST) begin
          bit_cnt_n = '0;
          tcnt_n    = '0;
          state_n   = S_SEND;
        end else begin
          dly_n = dly + 1'b1;
        end
      end
      S_SEND: begin
        if (fall) begin
          if (bit_cnt == 4'd10) begin
            state_n = S_ACK;
          end else begin
            data_oe_n = ~shift[0];
            shift_n   = {1'b1, shift[9:1]};
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (sdata_s2) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (sclk_s2 && sdata_s2) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Timeout overrides whatever the device did this cycle.
    if (timed) begin
      state_n   = S_IDLE;
      data_oe_n = 1'b0;
      done_n    = 1'b0;
      err_n     = 1'b1;
    end
  end

  assign SCLK_OE  = (state == S_INHIBIT) || (state == S_SETUP);
  assign SDATA_OE = data_oe;
  assign BUSY     = (state != S_IDLE);
  assign DONE     = done_r;
  assign ERR      = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx
// A behavioural PS/2 device clocks frames out of the host and records line bits.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int SET  = 5;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_START = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       sclk_line, sdata_line;
  logic       SCLK_OE, SDATA_OE, BUSY, DONE, ERR;

  int checks = 0;
  int errors = 0;

  assign sclk_line  = dev_clk & ~SCLK_OE;
  assign sdata_line = dev_data & ~SDATA_OE;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .TX_DATA (TX_DATA),
    .TX_START(TX_START),
    .SCLK_IN (sclk_line),
    .SDATA_IN(sdata_line),
    .SCLK_OE (SCLK_OE),
    .SDATA_OE(SDATA_OE),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Frame as the device sees it: start, D0..D7, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  int   cyc = 0, done_cnt = 0, err_cnt = 0;
  int   sclk_run = 0, last_run = 0, send_cyc = 0, err_cyc = 0;
  logic busy_prev = 1'b0;
  bit   mon_en = 1'b0;
  bit   mon_ok;

  // Per-cycle rules: pulse exclusivity, pulses only out of a busy cycle,
  // released lines when idle, start bit only in the last SETUP cycles.
  always @(negedge CLK) begin
    cyc++;
    if (mon_en) begin
      checks++;
      mon_ok = 1'b1;
      if (DONE && ERR) mon_ok = 1'b0;
      if ((DONE || ERR) && !busy_prev) mon_ok = 1'b0;
      if (!BUSY && (SCLK_OE || SDATA_OE)) mon_ok = 1'b0;
      if (SCLK_OE && (SDATA_OE !== (sclk_run + 1 > INH))) mon_ok = 1'b0;
      if (SCLK_OE && (sclk_run + 1 > INH + SET)) mon_ok = 1'b0;
      if (!mon_ok) begin
        errors++;
        $display("FAIL cycle_model cyc %0d: SCLK_OE=%b SDATA_OE=%b BUSY=%b DONE=%b ERR=%b busy_prev=%b run=%0d",
                 cyc, SCLK_OE, SDATA_OE, BUSY, DONE, ERR, busy_prev, sclk_run);
      end
    end
    if (DONE) done_cnt++;
    if (ERR) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (SCLK_OE) begin
      sclk_run++;
    end else begin
      if (sclk_run != 0) begin
        last_run = sclk_run;
        send_cyc = cyc;
      end
      sclk_run = 0;
    end
    busy_prev = BUSY;
  end

  task automatic host_start(input logic [7:0] b);
    @(negedge CLK);
    TX_DATA  = b;
    TX_START = 1'b1;
    @(negedge CLK);
    TX_START = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    int t;
    ok = 1'b1;
    t = 0;
    while (!SCLK_OE && t < 100) begin @(negedge CLK); t++; end
    if (!SCLK_OE) ok = 1'b0;
    t = 0;
    while (SCLK_OE && t < 100) begin @(negedge CLK); t++; end
    if (SCLK_OE) ok = 1'b0;
  endtask

  task automatic dev_xfer(input bit ack, output logic [10:0] frame, output bit ok);
    frame = '0;
    wait_release(ok);
    frame[0] = sdata_line;
    repeat (10) @(negedge CLK);
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLK);
      dev_clk = 1'b1;
      frame[k] = sdata_line;
      repeat (HALF) @(negedge CLK);
    end
    dev_clk = 1'b0;
    if (ack) dev_data = 1'b0;
    repeat (HALF) @(negedge CLK);
    dev_clk = 1'b1;
    repeat (5) @(negedge CLK);
    dev_data = 1'b1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (BUSY && t < 500) begin @(negedge CLK); t++; end
    check("busy_drop", int'(BUSY), 0);
  endtask

  task automatic do_send(input logic [7:0] b, input bit ack, output logic [10:0] fr);
    int d0, e0;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      host_start(b);
      dev_xfer(ack, fr, ok);
    join
    wait_idle();
    repeat (5) @(negedge CLK);
    check("xfer_seen", int'(ok), 1);
    check("frame_model", int'(fr), int'(frame_of(b)));
    check("sclk_low_run", last_run, INH + SET);
    check("done_pulses", done_cnt - d0, ack ? 1 : 0);
    check("err_pulses", err_cnt - e0, ack ? 0 : 1);
  endtask

  initial begin
    logic [10:0] fr;
    bit ok;
    int d0, e0, t;

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_sclk_oe", int'(SCLK_OE), 0);
    check("rst_sdata_oe", int'(SDATA_OE), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_err", int'(ERR), 0);
    RST = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(negedge CLK);

    do_send(8'hED, 1'b1, fr);
    check("frame_ED_literal", int'(fr), 32'h7DA);

    do_send(8'h01, 1'b1, fr);
    check("parity_01", int'(fr[9]), 0);
    check("frame_01_literal", int'(fr), 32'h402);

    do_send(8'hFF, 1'b1, fr);
    check("parity_FF", int'(fr[9]), 1);
    check("frame_FF_literal", int'(fr), 32'h7FE);

    // Device never clocks after release.
    e0 = err_cnt;
    d0 = done_cnt;
    host_start(8'h55);
    t = 0;
    while (err_cnt == e0 && t < 3000) begin @(negedge CLK); t++; end
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_latency", err_cyc - send_cyc, TO);
    repeat (2) @(negedge CLK);
    check("timeout_sclk_oe", int'(SCLK_OE), 0);
    check("timeout_sdata_oe", int'(SDATA_OE), 0);
    check("timeout_busy", int'(BUSY), 0);
    check("timeout_no_done", done_cnt - d0, 0);

    do_send(8'h3C, 1'b0, fr);
    do_send(8'h01, 1'b1, fr);
    check("after_noack_frame", int'(fr), 32'h402);

    // Second request while busy must be dropped.
    d0 = done_cnt;
    fork
      host_start(8'hF4);
      dev_xfer(1'b1, fr, ok);
      begin
        repeat (300) @(negedge CLK);
        TX_DATA  = 8'h00;
        TX_START = 1'b1;
        @(negedge CLK);
        TX_START = 1'b0;
      end
    join
    wait_idle();
    repeat (50) @(negedge CLK);
    check("ignore_seen", int'(ok), 1);
    check("ignore_frame_F4", int'(fr), 32'h5E8);
    check("ignore_parity_F4", int'(fr[9]), 0);
    check("ignore_one_done", done_cnt - d0, 1);
    check("ignore_not_queued", int'(BUSY), 0);

    // Reset in the middle of the data bits.
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      host_start(8'hA5);
      begin
        wait_release(ok);
        repeat (10) @(negedge CLK);
        for (int k = 1; k <= 4; k++) begin
          dev_clk = 1'b0;
          if (k < 4) begin
            repeat (HALF) @(negedge CLK);
            dev_clk = 1'b1;
            repeat (HALF) @(negedge CLK);
          end
        end
        repeat (8) @(negedge CLK);
      end
    join
    check("prerst_seen", int'(ok), 1);
    check("prerst_d3_low", int'(SDATA_OE), 1);
    check("prerst_busy", int'(BUSY), 1);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_sclk_oe", int'(SCLK_OE), 0);
    check("midrst_sdata_oe", int'(SDATA_OE), 0);
    check("midrst_busy", int'(BUSY), 0);
    dev_clk = 1'b1;
    RST = 1'b0;
    repeat (200) @(negedge CLK);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_err", err_cnt - e0, 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It is the send direction for the keyboard link that the existing keyboard decoder only receives.
- Sends one command byte (for example 0xED set-LEDs, 0xF4 enable) to the keyboard, using the PS/2 host request-to-send sequence with odd parity and device acknowledge.
- Sits beside the keyboard decoder in the top level and drives the open-collector SCLK/SDATA lines through output-enables. Each enable, when 1, pulls its line low.

Parameters:
- INHIBIT_CYCLES, 6000: CLK cycles the host holds clock low before the start bit (120 us at 50 MHz).
- SETUP_CYCLES, 250: CLK cycles data is held low with clock still low before clock is released.
- TIMEOUT_CYCLES, 750000: maximum CLK cycles from clock release to ack sampled (15 ms).

Ports:
- CLK  in  1  system clock (50 MHz).
- RST  in  1  synchronous reset, active-high.
- TX_DATA  in  8  command byte, sampled when a request is accepted.
- TX_START  in  1  one-cycle request strobe.
- SCLK_IN  in  1  raw PS/2 clock pin level (asynchronous).
- SDATA_IN  in  1  raw PS/2 data pin level (asynchronous).
- SCLK_OE  out  1  1 = pull PS/2 clock low.
- SDATA_OE  out  1  1 = pull PS/2 data low.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle pulse: byte sent and acknowledged.
- ERR  out  1  one-cycle pulse: timeout or missing ack.

Behaviour:
- Clock and reset: single clock domain, CLK. RST is synchronous and active-high. While RST is sampled 1, all state returns to IDLE, all counters clear, and SCLK_OE, SDATA_OE, BUSY, DONE and ERR are 0 on the following edge. This holds mid-frame too: both lines are released one cycle after RST.
- Input sync: SCLK_IN and SDATA_IN each pass through a 2-flop synchronizer. A previous-value register on the synced clock gives a falling-edge flag `fall`. `fall` is asserted 3 CLK cycles after the pin falls.
- Shift word: 10 bits, LSB first: D0..D7, then P = ~^TX_DATA (odd parity), then stop = 1. SDATA_OE is the inverse of the current bit (bit 0 drives the line low).
- IDLE:
  - BUSY=0, both OE=0.
  - TX_START=1 latches TX_DATA and goes to INHIBIT. On the next cycle BUSY=1 and SCLK_OE=1.
  - TX_START while BUSY=1 is ignored and not queued.
- INHIBIT: SCLK_OE=1 for INHIBIT_CYCLES cycles, then go to SETUP.
- SETUP: SCLK_OE=1 and SDATA_OE=1 (start bit) for SETUP_CYCLES cycles, then go to SEND.
- SEND:
  - SCLK_OE=0. The 4-bit bit counter starts at 0 and the timeout counter starts.
  - On each `fall` with count n (0..9), on the next cycle drive shift bit n and increment the counter.
  - The `fall` with n=9 drives stop, i.e. SDATA_OE=0. The next `fall` (the 11th) moves to ACK.
- ACK: on the same cycle as entering ACK, sample synced data.
  - Synced data = 0: acknowledged. Go to WAIT_IDLE.
  - Synced data = 1: ERR pulse, then IDLE.
- WAIT_IDLE: wait until synced clock = 1 and synced data = 1 for 1 cycle. Then DONE=1 for one cycle, BUSY drops with it, and go to IDLE.
- Timeout:
  - The timeout counter runs in SEND, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES-1 forces both OE=0, an ERR pulse and IDLE on the next cycle.
  - Timeout has priority over a simultaneous `fall`.
- DONE and ERR are mutually exclusive and never asserted when BUSY was 0 the prior cycle.
- `fall` events in IDLE, INHIBIT or SETUP are ignored (the device is inhibited, and our own pull-down creates them).

Test Plan:
- Bench uses INHIBIT_CYCLES=20, SETUP_CYCLES=5, TIMEOUT_CYCLES=2000, with a device model clocking at 40 CLK periods.
- Send 0xED with device ack:
  - SCLK_OE high exactly 25 cycles.
  - Line bits seen by device on rising edges: 0, 1,0,1,1,0,1,1,1, P=1, stop=1.
  - Ack accepted, one DONE pulse, ERR=0.
- Send 0x01: parity bit = 0 on line; DONE pulses. Then send 0xFF: parity bit = 1; DONE pulses.
- Device never toggles clock after release: ERR pulses exactly TIMEOUT_CYCLES cycles after entering SEND. Both OE=0 and BUSY=0 afterwards.
- Device leaves data high on the 11th clock (no ack): ERR pulses, DONE stays 0, next TX_START is accepted normally.
- TX_START pulsed with TX_DATA=0x00 mid-transfer of 0xF4: ignored. Device receives 0xF4 with parity 0 and exactly one DONE.
- RST asserted after the 4th falling edge: next cycle SCLK_OE=0, SDATA_OE=0, BUSY=0, and no DONE or ERR pulse.
